spi_trx_responder: RTL and testbench
====================================

// Module: spi_trx_responder
// PURPOSE
//  SPI mode-0 responder (device end) for the 24-bit command frames our SPI controller issues.
//  Oversamples SCLK/SS/MOSI in the fabric clock domain and decodes {cmd,addr,data} frames.
//  Backs an internal 8-bit register file: reads return register contents on MISO; writes update it.
//  Used as the on-FPGA peripheral model and as the loopback target for controller bring-up.
// PARAMETERS
//  DEPTH    256   number of 8-bit registers; addresses >= DEPTH are out of range
//  SYNC_FF  2     synchronizer flops on i_sclk/i_ss/i_mosi (min 2)
// PORTS
//  i_clk         in   1  fabric clock; all logic on rising edge
//  i_rstb        in   1  asynchronous active-low reset
//  i_sclk        in   1  SPI clock from controller, CPOL=0; async to i_clk
//  i_ss          in   1  slave select, active low
//  i_mosi        in   1  serial data in, MSB first
//  o_miso        out  1  serial data out, MSB first
//  o_miso_oe     out  1  high while selected (drives tri-state pad)
//  o_wr_stb      out  1  1-cycle pulse: SPI write committed
//  o_wr_addr     out  8  address of committed write
//  o_wr_data     out  8  data of committed write
//  o_frame_done  out  1  1-cycle pulse: well-formed frame ended (SS rose)
//  o_frame_err   out  1  1-cycle pulse: frame aborted or malformed
//  i_host_we     in   1  fabric-side register write enable
//  i_host_addr   in   8  fabric-side address (read and write)
//  i_host_wdata  in   8  fabric-side write data
//  o_host_rdata  out  8  regfile[i_host_addr], registered, 1-cycle latency
// BEHAVIOUR
//  - Reset: all outputs 0, regfile all 0x00, FSM IDLE, bit counter 0. Async assert, sync deassert.
//  - Frame bits [23:16] CMD (bit23: 1=read, 0=write; [22:16] ignored), [15:8] ADDR, [7:0] DATA.
//  - MOSI sampled on synchronized SCLK rising edge; MISO updated on falling edge.
//    i_sclk frequency <= i_clk/8.
//  - FSM: IDLE -(SS fall)-> CMD -(8 bits)-> ADDR -(8 bits)-> DATA -(8 bits)-> WAIT_SS -(SS rise)-> IDLE.
//    SS rise from any state -> IDLE.
//  - Read: on the cycle after ADDR's 8th bit, load shift-out register with regfile[ADDR]
//    (0x00 if out of range). Bit7 is driven by the next SCLK falling edge; MISO=0 during CMD/ADDR.
//  - Write: on the 24th sampled bit with bit23=0, o_wr_stb/addr/data pulse 1 cycle later;
//    regfile is updated in the same cycle. Out-of-range write: no update, no stb, o_frame_err at SS rise.
//  - Host write and SPI write same cycle, same address: SPI wins. Different addresses: both commit.
//  - SS rise with bit count != 24 -> o_frame_err, no write, regfile unchanged.
//    SS rise with count == 24 -> o_frame_done.
//  - Bits beyond 24 with SS low: ignored, MISO=0, and the frame is flagged as an error
//    (unless the macro below is enabled).
//  - o_miso_oe = synchronized ~SS; o_miso is 0 when oe=0.
//  - i_rstb low mid-frame: immediate return to reset state; pending write discarded.
// CONFIGURATION
//  SPI_TRX_RESP_BURST_EN defined:
//  - after byte 3, each further 8-bit group accesses ADDR+1, ADDR+2, ... with 8-bit wrap 0xFF->0x00.
//  - write mode: each full byte commits and pulses o_wr_stb.
//  - read mode: the next register is preloaded at each byte boundary.
//  - SS rise on a byte boundary -> frame_done; mid-byte -> frame_err, completed bytes stay committed.
//  Not defined: as described in BEHAVIOUR (count > 24 -> error).
// STRUCTURE
//  - Package spi_trx_pkg: FRAME_W=24, CMD_RD_BIT=23, BYTE_W=8, FSM state enum
//    (IDLE, CMD, ADDR, DATA, WAIT_SS), shared with the controller bench.
//  - Sub-module spi_sync_edge: SYNC_FF-stage synchronizer plus rise/fall pulse detect,
//    instantiated for SCLK, SS, MOSI.
// TESTING
//  - Write 0x00_12_A5, SS rise -> o_wr_stb once, addr 0x12, data 0xA5, frame_done; host read 0x12 = 0xA5.
//  - Host writes 0x3C to addr 0x40; SPI frame 0x80_40_00 -> MISO returns 0x3C MSB first; frame_done.
//  - SS rises after 13 bits of a write to 0x05 -> frame_err, no wr_stb, regfile[0x05] unchanged.
//  - DEPTH=16: write to 0x20 -> no stb, frame_err; read of 0x20 returns 0x00.
//  - Host and SPI write 0x07 in the same cycle (0x11 vs 0x22) -> regfile[0x07] = 0x22.
//  - BURST_EN: write 0x00_FE_01_02_03 -> stbs at FE=01, FF=02, 00=03; i_rstb pulse mid-frame -> all outputs 0.

Source files
------------

// File: rtl/spi_trx_pkg.sv
// Shared frame constants and FSM state type for the SPI responder and controller bench.
package spi_trx_pkg;

  localparam int unsigned FRAME_W    = 24;
  localparam int unsigned CMD_RD_BIT = 23;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    WAIT_SS
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_FF = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned NS = (SYNC_FF < 2) ? 2 : SYNC_FF;

  // One extra stage past the synchronized output holds the previous level for edge detect.
  logic [NS:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[NS-1:0], i_d};

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) sh_q <= {(NS + 1){RST_VAL}};
    else         sh_q <= sh_d;
  end

  assign o_q    = sh_q[NS-1];
  assign o_rise = sh_q[NS-1] & ~sh_q[NS];
  assign o_fall = ~sh_q[NS-1] & sh_q[NS];

endmodule

// File: rtl/spi_trx_responder.sv
// SPI mode-0 responder for 24-bit {cmd,addr,data} frames backed by an 8-bit register file.
// Define SPI_TRX_RESP_BURST_EN to let frames continue with auto-incrementing addresses.
module spi_trx_responder
  import spi_trx_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic       i_clk,
  input  logic       i_rstb,
  input  logic       i_sclk,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic       o_wr_stb,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_done,
  output logic       o_frame_err,
  input  logic       i_host_we,
  input  logic [7:0] i_host_addr,
  input  logic [7:0] i_host_wdata,
  output logic [7:0] o_host_rdata
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_LIM = (DEPTH > 256) ? 9'd256 : 9'(DEPTH);
  localparam logic [4:0]  CNT_SAT   = 5'(FRAME_W + 1);

  // Asynchronous assert, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rstb(rst_n), .i_d(i_sclk),
    .o_q(sclk_s), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );
  // SS idles high so the pad stays tri-stated through reset.
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rstb(rst_n), .i_d(i_ss),
    .o_q(ss_s), .o_rise(ss_rise), .o_fall(ss_fall)
  );
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rstb(rst_n), .i_d(i_mosi),
    .o_q(mosi_s), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  spi_state_e  state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic [7:0]  addr_q, addr_d;
  logic        err_q, err_d;
  logic        rd_load_q, rd_load_d;
  logic [7:0]  miso_sh_q, miso_sh_d;
  logic        miso_q, miso_d;
  logic        wr_stb_q, wr_stb_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic [7:0]  rf_q [DEPTH];
  logic [7:0]  rf_d [DEPTH];
  logic        spi_we;
  logic [7:0]  byte_in;
  logic        frame_ok;

  function automatic logic addr_ok(input logic [7:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    return addr_ok(a) ? rf_q[AW'(a)] : 8'h00;
  endfunction

  assign byte_in = {shreg_q[6:0], mosi_s};

`ifdef SPI_TRX_RESP_BURST_EN
  assign frame_ok = !err_q && (bcnt_q == 3'd0) && (bit_cnt_q >= 5'(FRAME_W));
`else
  assign frame_ok = !err_q && (bit_cnt_q == 5'(FRAME_W));
`endif

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    cmd_rd_d  = cmd_rd_q;
    addr_d    = addr_q;
    err_d     = err_q;
    miso_sh_d = miso_sh_q;
    miso_d    = miso_q;
    rd_load_d = 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = 8'h00;
    wr_data_d = 8'h00;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    spi_we    = 1'b0;

    if (rd_load_q) miso_sh_d = rd_val(addr_q);

    if (ss_rise) begin
      state_d   = IDLE;
      miso_sh_d = 8'h00;
      miso_d    = 1'b0;
      if (state_q != IDLE) begin
        done_d = frame_ok;
        ferr_d = !frame_ok;
      end
    end else if (ss_fall) begin
      state_d   = CMD;
      bcnt_d    = 3'd0;
      bit_cnt_d = 5'd0;
      err_d     = 1'b0;
      miso_sh_d = 8'h00;
      miso_d    = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclk_fall) begin
        miso_d    = miso_sh_q[7];
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      end
      if (sclk_rise) begin
        shreg_d = byte_in;
        bcnt_d  = bcnt_q + 3'd1;
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
        if (bcnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              cmd_rd_d = byte_in[BYTE_W-1];
              state_d  = ADDR;
            end
            ADDR: begin
              addr_d    = byte_in;
              state_d   = DATA;
              rd_load_d = cmd_rd_q;
            end
            DATA: begin
              if (!cmd_rd_q) begin
                if (addr_ok(addr_q)) begin
                  spi_we    = 1'b1;
                  wr_stb_d  = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = byte_in;
                end else begin
                  err_d = 1'b1;
                end
              end
`ifdef SPI_TRX_RESP_BURST_EN
              addr_d    = addr_q + 8'd1;
              rd_load_d = cmd_rd_q;
`else
              state_d = WAIT_SS;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Host write lands first so a same-address SPI write overrides it.
  always_comb begin
    rf_d = rf_q;
    if (i_host_we && addr_ok(i_host_addr)) rf_d[AW'(i_host_addr)] = i_host_wdata;
    if (spi_we) rf_d[AW'(addr_q)] = byte_in;
    host_rdata_d = rd_val(i_host_addr);
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bcnt_q       <= 3'd0;
      bit_cnt_q    <= 5'd0;
      shreg_q      <= 8'h00;
      cmd_rd_q     <= 1'b0;
      addr_q       <= 8'h00;
      err_q        <= 1'b0;
      rd_load_q    <= 1'b0;
      miso_sh_q    <= 8'h00;
      miso_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= 8'h00;
      wr_data_q    <= 8'h00;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
      host_rdata_q <= 8'h00;
      rf_q         <= '{default: 8'h00};
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      cmd_rd_q     <= cmd_rd_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      rd_load_q    <= rd_load_d;
      miso_sh_q    <= miso_sh_d;
      miso_q       <= miso_d;
      wr_stb_q     <= wr_stb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      ferr_q       <= ferr_d;
      host_rdata_q <= host_rdata_d;
      rf_q         <= rf_d;
    end
  end

  assign o_miso_oe    = ~ss_s;
  assign o_miso       = miso_q & ~ss_s;
  assign o_wr_stb     = wr_stb_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = ferr_q;
  assign o_host_rdata = host_rdata_q;

endmodule

// File: tb/tb_spi_trx_responder.sv
// Directed bench: table of SPI frames with hand-computed results plus corner-case sequences.
module tb_spi_trx_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       ss16 = 1'b1;
  logic       mosi = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_wdata = 8'h00;
  logic       host_we16 = 1'b0;
  logic [7:0] host_addr16 = 8'h00;
  logic [7:0] host_wdata16 = 8'h00;

  logic       miso, oe, wr_stb, fdone, ferr;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic       miso16, oe16, wr_stb16, fdone16, ferr16;
  logic [7:0] wr_addr16, wr_data16, host_rdata16;

  always #5 clk = ~clk;

  spi_trx_responder #(.DEPTH(256), .SYNC_FF(2)) dut (
    .i_clk(clk), .i_rstb(rstb), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(oe), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_frame_done(fdone), .o_frame_err(ferr),
    .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_rdata(host_rdata)
  );

  spi_trx_responder #(.DEPTH(16), .SYNC_FF(2)) dut16 (
    .i_clk(clk), .i_rstb(rstb), .i_sclk(sclk), .i_ss(ss16), .i_mosi(mosi),
    .o_miso(miso16), .o_miso_oe(oe16), .o_wr_stb(wr_stb16), .o_wr_addr(wr_addr16),
    .o_wr_data(wr_data16), .o_frame_done(fdone16), .o_frame_err(ferr16),
    .i_host_we(host_we16), .i_host_addr(host_addr16), .i_host_wdata(host_wdata16),
    .o_host_rdata(host_rdata16)
  );

  int n_vec = 0;
  int n_bad = 0;

  int n_stb = 0, n_done = 0, n_err = 0;
  int n_stb16 = 0, n_done16 = 0, n_err16 = 0;
  logic [7:0] log_addr [16];
  logic [7:0] log_data [16];

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      log_addr[n_stb % 16] = wr_addr;
      log_data[n_stb % 16] = wr_data;
      n_stb++;
    end
    if (fdone === 1'b1) n_done++;
    if (ferr === 1'b1) n_err++;
    if (wr_stb16 === 1'b1) n_stb16++;
    if (fdone16 === 1'b1) n_done16++;
    if (ferr16 === 1'b1) n_err16++;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input bit sel16, input logic [47:0] frame, input int nbits,
                            input bit conflict, output logic [47:0] cap);
    int k;
    cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = frame[i];
      repeat (HALF) @(negedge clk);
      cap = {cap[46:0], (sel16 ? miso16 : miso)};
      if (conflict && i == 0) begin
        host_we    = 1'b1;
        host_addr  = 8'h07;
        host_wdata = 8'h11;
      end
      sclk = 1'b1;
      if (conflict && i == 0) begin
        k = 0;
        while (wr_stb !== 1'b1 && k < 100) begin
          @(negedge clk);
          k++;
        end
        host_we = 1'b0;
        check("conflict_stb_seen", 48'(wr_stb), 48'd1);
      end
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input bit sel16, input logic [47:0] frame, input int nbits,
                      input bit conflict, output logic [47:0] cap);
    if (sel16) ss16 = 1'b0;
    else       ss = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(sel16, frame, nbits, conflict, cap);
    repeat (HALF) @(negedge clk);
    ss   = 1'b1;
    ss16 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  typedef struct {
    logic [47:0] frame;
    int          nbits;
    int          d_stb;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    int          d_done;
    int          d_err;
    logic [47:0] miso;
    logic [7:0]  raddr;
    logic [7:0]  rdata;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [47:0] cap;
    logic [7:0]  rd;
    int s0, d0, e0;

    tbl[0] = '{48'h0012A5, 24, 1, 8'h12, 8'hA5, 1, 0, 48'h0, 8'h12, 8'hA5};
    tbl[1] = '{48'h801200, 24, 0, 8'h00, 8'h00, 1, 0, 48'hA5, 8'h12, 8'hA5};
    tbl[2] = '{48'h00055A, 24, 1, 8'h05, 8'h5A, 1, 0, 48'h0, 8'h05, 8'h5A};
    tbl[3] = '{48'h000000, 13, 0, 8'h00, 8'h00, 0, 1, 48'h0, 8'h05, 8'h5A};
    tbl[4] = '{48'h800500, 24, 0, 8'h00, 8'h00, 1, 0, 48'h5A, 8'h05, 8'h5A};
    tbl[5] = '{48'h7F80C3, 24, 1, 8'h80, 8'hC3, 1, 0, 48'h0, 8'h80, 8'hC3};
    tbl[6] = '{48'hFF8000, 24, 0, 8'h00, 8'h00, 1, 0, 48'hC3, 8'h80, 8'hC3};
    tbl[7] = '{48'h804000, 24, 0, 8'h00, 8'h00, 1, 0, 48'h3C, 8'h40, 8'h3C};
`ifdef SPI_TRX_RESP_BURST_EN
    tbl[8] = '{48'h00307700, 32, 2, 8'h31, 8'h00, 1, 0, 48'h0, 8'h30, 8'h77};
`else
    tbl[8] = '{48'h00307700, 32, 1, 8'h30, 8'h77, 0, 1, 48'h0, 8'h30, 8'h77};
`endif
    tbl[9] = '{48'h000000, 0, 0, 8'h00, 8'h00, 0, 1, 48'h0, 8'h30, 8'h77};

    #1 rstb = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", 48'({oe, miso, wr_stb, fdone, ferr, wr_addr, wr_data, host_rdata}),
          48'h0);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    host_read(8'h12, rd);
    check("reset_regfile", 48'(rd), 48'h0);

    @(negedge clk);
    host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h3C;
    @(negedge clk);
    host_we = 1'b0;

    for (int v = 0; v < 10; v++) begin
      s0 = n_stb; d0 = n_done; e0 = n_err;
      xfer(1'b0, tbl[v].frame, tbl[v].nbits, 1'b0, cap);
      check($sformatf("v%0d stb_count", v), 48'(n_stb - s0), 48'(tbl[v].d_stb));
      if (tbl[v].d_stb > 0) begin
        check($sformatf("v%0d wr_addr", v), 48'(log_addr[(n_stb - 1) % 16]), 48'(tbl[v].waddr));
        check($sformatf("v%0d wr_data", v), 48'(log_data[(n_stb - 1) % 16]), 48'(tbl[v].wdata));
      end
      check($sformatf("v%0d frame_done", v), 48'(n_done - d0), 48'(tbl[v].d_done));
      check($sformatf("v%0d frame_err", v), 48'(n_err - e0), 48'(tbl[v].d_err));
      check($sformatf("v%0d miso", v), cap, tbl[v].miso);
      host_read(tbl[v].raddr, rd);
      check($sformatf("v%0d host_rdata", v), 48'(rd), 48'(tbl[v].rdata));
    end

    // Host and SPI write the same register on the same edge.
    xfer(1'b0, 48'h000722, 24, 1'b1, cap);
    host_read(8'h07, rd);
    check("conflict_regfile", 48'(rd), 48'h22);

    // Out-of-range access on the 16-entry instance.
    s0 = n_stb16; d0 = n_done16; e0 = n_err16;
    xfer(1'b1, 48'h002055, 24, 1'b0, cap);
    check("d16_oor_stb", 48'(n_stb16 - s0), 48'd0);
    check("d16_oor_err", 48'(n_err16 - e0), 48'd1);
    check("d16_oor_done", 48'(n_done16 - d0), 48'd0);
    d0 = n_done16;
    xfer(1'b1, 48'h802000, 24, 1'b0, cap);
    check("d16_oor_miso", cap, 48'h0);
    check("d16_rd_done", 48'(n_done16 - d0), 48'd1);
    @(negedge clk);
    host_addr16 = 8'h20;
    @(negedge clk);
    check("d16_host_rdata", 48'(host_rdata16), 48'h0);

    // Frame longer than 24 bits.
    s0 = n_stb; d0 = n_done; e0 = n_err;
    xfer(1'b0, 48'h00FE010203, 40, 1'b0, cap);
`ifdef SPI_TRX_RESP_BURST_EN
    check("long_stb_count", 48'(n_stb - s0), 48'd3);
    check("long_stb0", 48'({log_addr[s0 % 16], log_data[s0 % 16]}), 48'hFE01);
    check("long_stb1", 48'({log_addr[(s0 + 1) % 16], log_data[(s0 + 1) % 16]}), 48'hFF02);
    check("long_stb2", 48'({log_addr[(s0 + 2) % 16], log_data[(s0 + 2) % 16]}), 48'h0003);
    check("long_done", 48'(n_done - d0), 48'd1);
    check("long_err", 48'(n_err - e0), 48'd0);
    host_read(8'hFF, rd);
    check("long_rd_ff", 48'(rd), 48'h02);
`else
    check("long_stb_count", 48'(n_stb - s0), 48'd1);
    check("long_stb0", 48'({log_addr[s0 % 16], log_data[s0 % 16]}), 48'hFE01);
    check("long_done", 48'(n_done - d0), 48'd0);
    check("long_err", 48'(n_err - e0), 48'd1);
    host_read(8'hFF, rd);
    check("long_rd_ff", 48'(rd), 48'h00);
`endif

    // Reset pulse in the middle of a write frame.
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(1'b0, 48'h0012, 12, 1'b0, cap);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outputs", 48'({oe, miso, wr_stb, fdone, ferr, wr_addr, wr_data, host_rdata}),
          48'h0);
    s0 = n_stb; d0 = n_done; e0 = n_err;
    ss = 1'b1;
    repeat (5) @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_pulses", 48'((n_stb - s0) + (n_done - d0) + (n_err - e0)), 48'd0);
    host_read(8'h12, rd);
    check("midreset_regfile", 48'(rd), 48'h00);
    xfer(1'b0, 48'h001299, 24, 1'b0, cap);
    host_read(8'h12, rd);
    check("after_reset_write", 48'(rd), 48'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
